issue_queue: RTL
================

# issue_queue

Dual-issue instruction buffer between the decode stage and the issue/execute pipeline register. Accepts up to two decoded `FU_REQUIRE` entries per cycle from ID, holds them in a circular buffer, and each cycle presents up to two in-order, hazard-screened requests toward EX. It decouples front-end fetch/decode bubbles from back-end stalls and enforces the in-order pairing rules for the MIPS delay slot.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, ≥ 4.

Ports:
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  back-end stall; when high, nothing is dequeued.
- `flash`  in  1  pipeline flush; when high, all entries are discarded.
- `id_in`  in  `FU_REQUIRE[1:0]`  decoded requests; slot 0 is older. A slot is present when its `.valid` is high.
- `id_ready`  out  1  high when at least 2 entries are free, based on the registered count.
- `is_out`  out  `FU_REQUIRE[1:0]`  requests issued this cycle. Slot 0 is older. A non-issued slot is all-zero.

`FU_REQUIRE` fields used: `valid`, `is_mem`, `is_branch`, `rd`, `rd_we`, `rs`, `rs_used`, `rt`, `rt_used`.

## Operation
- **Storage:** `DEPTH` entries, plus `head`/`tail` pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus `count` of log2(DEPTH)+1 bits.
- **Enqueue:**
  - Valid input slots are written when `id_ready` is high. Entries are written compactly at `tail`, keeping slot-0-before-slot-1 order.
  - If only slot 1 is valid, it goes to `tail`.
  - ID must hold its inputs when `id_ready` is low. Inputs presented while `id_ready` is low are ignored.
- **Issue selection** (combinational from `head`):
  - `head0` issues when `count ≥ 1`, with one exception: `head0.is_branch` and `count < 2`. In that case nothing issues, because the branch waits for its delay slot.
  - If `head0.is_branch` and `count ≥ 2`, `head0` and `head1` always issue together.
  - Otherwise `head1` issues with `head0` only when all of the following hold:
    - `count ≥ 2`;
    - not both are `is_mem`;
    - `head1.is_branch` is low;
    - no RAW hazard. A RAW hazard exists when `head0.rd_we`, `head0.rd != 0`, and (`head1.rs_used` with `rs == head0.rd`, or `head1.rt_used` with `rt == head0.rd`).
- **Output gating:** `is_out` shows the selected requests regardless of `stall`. Downstream ignores them while stalled.
- **Dequeue:** when `stall` is low, `head` advances and `count` drops by the number issued. When `stall` is high, there is no dequeue and enqueue still proceeds.
- **Same-cycle count update:** `count_next = count + enq - deq`.
- **Flash:** `head`, `tail` and `count` are cleared to 0. Flash overrides any same-cycle enqueue and dequeue.
- **Reset values:** `count = 0`, `head = tail = 0`, `id_ready = 1`, `is_out = '{default:0}`.

## Timing
- **Latency:** an entry enqueued at edge N can appear on `is_out` in the cycle after edge N (one-cycle ID→IS latency). There is no bypass of an empty queue.
- **`id_ready`:** derived only from the registered `count` (`DEPTH - count ≥ 2`). It does not account for a same-cycle dequeue, so there is no combinational path from `stall` to `id_ready`.
- **Full boundary:** with `count = DEPTH-1`, `id_ready` is low even though one entry is free.
- **Wrap-around:** pointers wrap from DEPTH-1 to 0 with no lost or duplicated entry. This includes a 2-entry write that straddles the wrap point.
- **Reset and flash precedence:** reset has priority over flash, and flash over everything else. The cycle after either, `is_out` is all-zero.

## Configuration
- `ISSUE_DUAL_EN`:
  - **Defined:** dual-issue pairing as described above.
  - **Undefined:**
    - Slot 1 of `is_out` is constantly zero and at most one entry dequeues per cycle.
    - The branch delay-slot wait rule is removed: a branch issues alone once at the head.
    - Enqueue width and `id_ready` are unchanged.

## Test plan
- **Reset/empty:** assert `rst` for 2 cycles → `id_ready = 1` and `is_out` all-zero. Enqueue one ALU op → the next cycle `is_out[0]` equals it and `is_out[1]` is zero.
- **RAW split:** enqueue `addu $3,$1,$2` then `addu $4,$3,$5` → cycle 1 issues only slot 0; cycle 2 issues the second request in slot 0.
- **Mem pair and branch in slot 1:**
  - `lw` + `sw` issue on separate cycles.
  - ALU + `beq` → the ALU op issues alone.
  - Next cycle, `beq` with its delay slot present issues as a pair.
- **Delay-slot wait:** enqueue `beq` alone and hold ID idle for 3 cycles → `is_out` stays zero. Enqueue the delay slot → both issue in the following cycle.
- **Full/wrap/stall:** with `DEPTH = 8`, hold `stall` high and enqueue 2 per cycle → `id_ready` drops when `count = 7` or 8, and `is_out` holds steady. Release `stall` → all 8 drain in order across the pointer wrap.
- **Flash mid-stream:** with `count = 5` and a simultaneous 2-entry enqueue, pulse `flash` → next cycle `count = 0`, `is_out` all-zero, `id_ready = 1`. Rebuild with `ISSUE_DUAL_EN` undefined → at most one issue per cycle.

Source files
------------

// File: rtl/issue_queue.sv
// issue_queue: in-order issue buffer between decode (ID) and the issue/execute
// register. Takes up to two decoded requests per cycle and presents up to two
// hazard-screened requests per cycle, oldest in slot 0.
// Optional feature macro: ISSUE_DUAL_EN. When defined, pair issue and the
// branch delay-slot wait are enabled. When undefined, one entry issues per cycle.

package issue_queue_pkg;
    typedef struct packed {
        logic       valid;
        logic       is_mem;
        logic       is_branch;
        logic [4:0] rd;
        logic       rd_we;
        logic [4:0] rs;
        logic       rs_used;
        logic [4:0] rt;
        logic       rt_used;
    } FU_REQUIRE;
endpackage

module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flash,
    input  FU_REQUIRE [1:0] id_in,
    output logic            id_ready,
    output FU_REQUIRE [1:0] is_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage holds data only, so it is never reset; validity comes from count.
    FU_REQUIRE     mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          wr0_en;
    logic          wr1_en;
    logic [PW-1:0] wr1_idx;
    logic [1:0]    enq_n;
    logic [1:0]    deq_n;
    logic [1:0]    deq_eff;
    logic          iss0;
    FU_REQUIRE     h0;

    // id_ready looks only at the registered count, so stall never reaches it.
    assign id_ready = (count <= CW'(DEPTH - 2));

    // Pack the valid input slots at tail, slot 0 first; a lone slot 1 lands on tail.
    always_comb begin
        wr0_en  = id_ready & id_in[0].valid;
        wr1_en  = id_ready & id_in[1].valid;
        wr1_idx = wr0_en ? tail + PW'(1) : tail;
        enq_n   = {1'b0, wr0_en} + {1'b0, wr1_en};
    end

    // Write the accepted requests into the circular buffer.
    always_ff @(posedge clk) begin
        if (wr0_en) mem[tail] <= id_in[0];
        if (wr1_en) mem[wr1_idx] <= id_in[1];
    end

    assign h0 = mem[head];

`ifdef ISSUE_DUAL_EN
    FU_REQUIRE h1;
    logic      iss1;
    logic      raw;

    assign h1 = mem[head + PW'(1)];

    // Select which of the two oldest entries may leave together this cycle.
    always_comb begin
        raw  = h0.rd_we && (h0.rd != 5'd0) &&
               ((h1.rs_used && (h1.rs == h0.rd)) || (h1.rt_used && (h1.rt == h0.rd)));
        iss0 = 1'b0;
        iss1 = 1'b0;
        if (count >= CW'(2)) begin
            if (h0.is_branch) begin
                // A branch always leaves with its delay slot.
                iss0 = 1'b1;
                iss1 = 1'b1;
            end else begin
                iss0 = 1'b1;
                iss1 = !(h0.is_mem && h1.is_mem) && !h1.is_branch && !raw;
            end
        end else if (count == CW'(1)) begin
            // A lone branch waits until its delay slot has arrived.
            iss0 = !h0.is_branch;
        end
        deq_n = {1'b0, iss0} + {1'b0, iss1};
    end

    // Drive the issue slots; a slot that does not issue is all-zero.
    always_comb begin
        is_out = '0;
        if (iss0) is_out[0] = h0;
        if (iss1) is_out[1] = h1;
    end
`else
    // Single issue: the head leaves whenever the queue is non-empty.
    always_comb begin
        iss0  = (count != '0);
        deq_n = {1'b0, iss0};
    end

    // Drive slot 0 only; slot 1 stays zero in this build.
    always_comb begin
        is_out = '0;
        if (iss0) is_out[0] = h0;
    end
`endif

    // A stalled back end dequeues nothing, though enqueue continues.
    assign deq_eff = stall ? 2'd0 : deq_n;

    // Pointer and occupancy update; reset beats flash, flash beats enqueue/dequeue.
    always_ff @(posedge clk) begin
        if (rst || flash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PW'(enq_n);
            head  <= head + PW'(deq_eff);
            count <= count + CW'(enq_n) - CW'(deq_eff);
        end
    end

endmodule
